// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port 4096x24 synchronous memory.
// A has priority, and a burst limit on A's consecutive wins keeps B from starving.
module mem_arbiter #(
    parameter int unsigned P_MAX_BURST = 4,
    localparam int unsigned ADDR_W = 12,
    localparam int unsigned DATA_W = 24
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_en,
    input  logic              iw_a_req,
    input  logic              iw_a_we,
    input  logic [ADDR_W-1:0] iw_a_addr,
    input  logic [DATA_W-1:0] iw_a_wdata,
    output logic              or_a_gnt,
    output logic              or_a_rvalid,
    output logic [DATA_W-1:0] or_a_rdata,
    input  logic              iw_b_req,
    input  logic              iw_b_we,
    input  logic [ADDR_W-1:0] iw_b_addr,
    input  logic [DATA_W-1:0] iw_b_wdata,
    output logic              or_b_gnt,
    output logic              or_b_rvalid,
    output logic [DATA_W-1:0] or_b_rdata,
    output logic              or_mem_we,
    output logic [ADDR_W-1:0] or_mem_addr,
    output logic [DATA_W-1:0] or_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata
);

    localparam int unsigned CNT_RAW = $clog2(P_MAX_BURST + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_MAX_BURST);
    localparam bit BURST_EN = (P_MAX_BURST != 0);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e            r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rv_a;
    logic             r_rv_b;

    logic             a_gnt_c;
    logic             b_gnt_c;
    logic             xfer_c;
    logic             burst_lim_c;
    port_e            winner_c;
    logic [CNT_W-1:0] cnt_nxt_c;

    // Winner selection; reset low suppresses grants so nothing leaks during reset.
    always_comb begin
        a_gnt_c     = 1'b0;
        b_gnt_c     = 1'b0;
        burst_lim_c = BURST_EN && (r_last == PORT_A) && (r_cnt >= CNT_MAX);
        if (iw_rst_n && iw_en) begin
            if (iw_a_req && iw_b_req) begin
                a_gnt_c = !burst_lim_c;
                b_gnt_c = burst_lim_c;
            end else begin
                a_gnt_c = iw_a_req;
                b_gnt_c = iw_b_req;
            end
        end
        xfer_c   = a_gnt_c || b_gnt_c;
        winner_c = b_gnt_c ? PORT_B : PORT_A;
    end

    // Saturating run length of consecutive wins by the same port.
    always_comb begin
        cnt_nxt_c = CNT_W'(1);
        if (winner_c == r_last) begin
            cnt_nxt_c = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
        end
    end

    // Memory port drive: idle cycles present a harmless read of address 0.
    always_comb begin
        or_mem_we    = 1'b0;
        or_mem_addr  = '0;
        or_mem_wdata = '0;
        if (a_gnt_c) begin
            or_mem_we    = iw_a_we;
            or_mem_addr  = iw_a_addr;
            or_mem_wdata = iw_a_wdata;
        end else if (b_gnt_c) begin
            or_mem_we    = iw_b_we;
            or_mem_addr  = iw_b_addr;
            or_mem_wdata = iw_b_wdata;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_last <= PORT_B;
            r_cnt  <= '0;
            r_rv_a <= 1'b0;
            r_rv_b <= 1'b0;
        end else begin
            if (xfer_c) begin
                r_last <= winner_c;
                r_cnt  <= cnt_nxt_c;
            end
            r_rv_a <= a_gnt_c && !iw_a_we;
            r_rv_b <= b_gnt_c && !iw_b_we;
        end
    end

    assign or_a_gnt    = a_gnt_c;
    assign or_b_gnt    = b_gnt_c;
    assign or_a_rvalid = r_rv_a;
    assign or_b_rvalid = r_rv_b;
    assign or_a_rdata  = r_rv_a ? iw_mem_rdata : '0;
    assign or_b_rdata  = r_rv_b ? iw_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed grant checks plus a read-response scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        a_req = 0, a_we = 0;
    logic [11:0] a_addr = '0;
    logic [23:0] a_wdata = '0;
    logic        b_req = 0, b_we = 0;
    logic [11:0] b_addr = '0;
    logic [23:0] b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [23:0] a_rdata, b_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;

    // Second instance with strict A priority.
    logic        z_a_req = 0, z_b_req = 0;
    logic        z_a_gnt, z_a_rvalid, z_b_gnt, z_b_rvalid, z_mem_we;
    logic [23:0] z_a_rdata, z_b_rdata, z_mem_wdata;
    logic [11:0] z_mem_addr;

    typedef struct {
        logic [23:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic due_a, due_b;
    logic [23:0] mem [4096];

    mem_arbiter #(.P_MAX_BURST(4)) dut (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_en(en),
        .iw_a_req(a_req), .iw_a_we(a_we), .iw_a_addr(a_addr), .iw_a_wdata(a_wdata),
        .or_a_gnt(a_gnt), .or_a_rvalid(a_rvalid), .or_a_rdata(a_rdata),
        .iw_b_req(b_req), .iw_b_we(b_we), .iw_b_addr(b_addr), .iw_b_wdata(b_wdata),
        .or_b_gnt(b_gnt), .or_b_rvalid(b_rvalid), .or_b_rdata(b_rdata),
        .or_mem_we(mem_we), .or_mem_addr(mem_addr), .or_mem_wdata(mem_wdata),
        .iw_mem_rdata(mem_rdata)
    );

    mem_arbiter #(.P_MAX_BURST(0)) dut_strict (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_en(1'b1),
        .iw_a_req(z_a_req), .iw_a_we(1'b0), .iw_a_addr(12'h100), .iw_a_wdata(24'h0),
        .or_a_gnt(z_a_gnt), .or_a_rvalid(z_a_rvalid), .or_a_rdata(z_a_rdata),
        .iw_b_req(z_b_req), .iw_b_we(1'b0), .iw_b_addr(12'h200), .iw_b_wdata(24'h0),
        .or_b_gnt(z_b_gnt), .or_b_rvalid(z_b_rvalid), .or_b_rdata(z_b_rdata),
        .or_mem_we(z_mem_we), .or_mem_addr(z_mem_addr), .or_mem_wdata(z_mem_wdata),
        .iw_mem_rdata(24'h0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory model, 1-cycle read latency.
    initial for (int i = 0; i < 4096; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Response monitor: every cycle rvalid must match whether a response is due.
    always @(negedge clk) begin
        due_a = (qa.size() > 0) && (qa[0].cyc == cyc);
        due_b = (qb.size() > 0) && (qb[0].cyc == cyc);
        chk("a_rvalid", 32'(a_rvalid), 32'(due_a));
        chk("b_rvalid", 32'(b_rvalid), 32'(due_b));
        if (due_a) begin
            chk("a_rdata", 32'(a_rdata), 32'(qa[0].data));
            void'(qa.pop_front());
        end else chk("a_rdata_idle", 32'(a_rdata), 32'h0);
        if (due_b) begin
            chk("b_rdata", 32'(b_rdata), 32'(qb[0].data));
            void'(qb.pop_front());
        end else chk("b_rdata_idle", 32'(b_rdata), 32'h0);
    end

    task automatic set_a(input logic req, input logic we, input logic [11:0] ad, input logic [23:0] wd);
        a_req = req; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [11:0] ad, input logic [23:0] wd);
        b_req = req; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    // One cycle: check grants and mem drive, queue expected read data.
    task automatic step(input string nm, input logic eag, input logic ebg,
                        input logic [23:0] ard, input logic [23:0] brd);
        logic        ewe;
        logic [11:0] eaddr;
        logic [23:0] ewd;
        @(negedge clk);
        ewe = 1'b0; eaddr = '0; ewd = '0;
        if (eag) begin ewe = a_we; eaddr = a_addr; ewd = a_wdata; end
        else if (ebg) begin ewe = b_we; eaddr = b_addr; ewd = b_wdata; end
        chk({nm, "/a_gnt"}, 32'(a_gnt), 32'(eag));
        chk({nm, "/b_gnt"}, 32'(b_gnt), 32'(ebg));
        chk({nm, "/mem_we"}, 32'(mem_we), 32'(ewe));
        chk({nm, "/mem_addr"}, 32'(mem_addr), 32'(eaddr));
        chk({nm, "/mem_wdata"}, 32'(mem_wdata), 32'(ewd));
        if (eag && !a_we) qa.push_back('{ard, cyc + 1});
        if (ebg && !b_we) qb.push_back('{brd, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset: requests present but nothing may be granted or driven.
        set_a(1, 1, 12'h123, 24'h777777);
        set_b(1, 1, 12'h456, 24'h888888);
        @(negedge clk);
        chk("rst/a_gnt", 32'(a_gnt), 0);
        chk("rst/b_gnt", 32'(b_gnt), 0);
        chk("rst/mem_we", 32'(mem_we), 0);
        chk("rst/mem_addr", 32'(mem_addr), 0);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: A write then read; B write in the response cycle.
        set_a(1, 1, 12'h010, 24'hABCDEF);
        step("t1_wr", 1, 0, 0, 0);
        set_a(1, 0, 12'h010, 24'h0);
        step("t1_rd", 1, 0, 24'hABCDEF, 0);
        set_a(0, 0, 0, 0);
        set_b(1, 1, 12'h020, 24'h55AA55);
        step("t1_bwr", 0, 1, 0, 0);

        // 2: continuous contention, burst limit 4.
        set_a(1, 0, 12'h010, 24'h0);
        set_b(1, 0, 12'h020, 24'h0);
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) step("t2_b", 0, 1, 0, 24'h55AA55);
            else step("t2_a", 1, 0, 24'hABCDEF, 0);
        end

        // 4: read just before disable; response still arrives.
        step("t4_pre", 1, 0, 24'hABCDEF, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step("t4_dis", 0, 0, 0, 0);
        en = 1'b1;
        step("t4_re", 1, 0, 24'hABCDEF, 0);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        step("t4_idle", 0, 0, 0, 0);

        // 3: strict priority instance never grants B while A requests.
        z_a_req = 1'b1;
        z_b_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t3_b_gnt", 32'(z_b_gnt), 0);
            @(posedge clk); #1;
        end
        z_a_req = 1'b0;
        @(negedge clk);
        chk("t3_b_gnt_drop", 32'(z_b_gnt), 1);
        @(posedge clk); #1;
        z_b_req = 1'b0;

        // 5: reset while a B read is in flight.
        set_b(1, 0, 12'h020, 24'h0);
        step("t5_brd", 0, 1, 0, 24'h55AA55);
        qb.delete();
        chk("t5_inflight", 32'(b_rvalid), 1);
        set_a(1, 0, 12'h010, 24'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_a_gnt", 32'(a_gnt), 0);
        chk("t5_rst_b_gnt", 32'(b_gnt), 0);
        chk("t5_rst_b_rvalid", 32'(b_rvalid), 0);
        chk("t5_rst_b_rdata", 32'(b_rdata), 0);
        chk("t5_rst_mem_we", 32'(mem_we), 0);
        chk("t5_rst_mem_addr", 32'(mem_addr), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) step("t5_b", 0, 1, 0, 24'h55AA55);
            else step("t5_a", 1, 0, 24'hABCDEF, 0);
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        step("t5_idle", 0, 0, 0, 0);

        // 6: same-address write/read collision on 0xFFF.
        set_a(1, 1, 12'hFFF, 24'h0A0B0C);
        step("t6_awr", 1, 0, 0, 0);
        set_a(1, 0, 12'hFFF, 24'h0);
        set_b(1, 1, 12'hFFF, 24'h123456);
        step("t6_old", 1, 0, 24'h0A0B0C, 0);
        set_a(0, 0, 0, 0);
        step("t6_bwr", 0, 1, 0, 0);
        set_b(0, 0, 0, 0);
        set_a(1, 0, 12'hFFF, 24'h0);
        for (int i = 0; i < 4; i++) step("t6_new", 1, 0, 24'h123456, 0);
        set_b(1, 1, 12'hFFF, 24'h654321);
        step("t6_lim", 0, 1, 0, 0);
        set_b(0, 0, 0, 0);
        step("t6_after", 1, 0, 24'h654321, 0);
        set_a(0, 0, 0, 0);
        step("t6_idle", 0, 0, 0, 0);
        step("t6_idle", 0, 0, 0, 0);

        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
